// File: rtl/vga_capture_pkg.sv
// Shared definitions for the VGA frame decimating capture block:
// default geometry, bus widths and the capture FSM state type.
package vga_capture_pkg;

  localparam int DECIM_DEF = 10;
  localparam int OUT_W_DEF = 192;
  localparam int OUT_H_DEF = 108;

  localparam int ADDR_W = 15;
  localparam int PIX_W  = 24;
  localparam int MEAS_W = 12;

  typedef enum logic [1:0] {
    ST_WAIT_VS = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2
  } cap_state_e;

endpackage

// File: rtl/vga_capture_if.sv
// Video input bus and frame-buffer write port of the capture block.
// slave: the capture block; master: the video source / frame buffer side.
interface vga_capture_if;
  import vga_capture_pkg::*;

  logic              vga_hs;
  logic              vga_vs;
  logic              vga_de;
  logic [7:0]        vga_r;
  logic [7:0]        vga_g;
  logic [7:0]        vga_b;

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [PIX_W-1:0]  wr_data;

  modport master (
    output vga_hs, vga_vs, vga_de, vga_r, vga_g, vga_b,
    input  wr_en, wr_addr, wr_data
  );

  modport slave (
    input  vga_hs, vga_vs, vga_de, vga_r, vga_g, vga_b,
    output wr_en, wr_addr, wr_data
  );

endinterface

// File: rtl/vga_sync_edge.sv
// Input register stage for the video bus plus vsync-fall / de-fall
// detection. Edges are found between the registered copy and a second
// delayed copy so they line up with the registered pixel.
module vga_sync_edge
  import vga_capture_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             hs_in,
  input  logic             vs_in,
  input  logic             de_in,
  input  logic [7:0]       r_in,
  input  logic [7:0]       g_in,
  input  logic [7:0]       b_in,
  output logic             hs_q,
  output logic             de_q,
  output logic [PIX_W-1:0] pix_q,
  output logic             vs_fall,
  output logic             de_fall
);

  logic vs_q;
  logic vs_q2;
  logic de_q2;

  // register video inputs once, keep one more copy of vs/de for edges
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hs_q  <= 1'b1;
      vs_q  <= 1'b1;
      de_q  <= 1'b0;
      pix_q <= '0;
      vs_q2 <= 1'b1;
      de_q2 <= 1'b0;
    end else begin
      hs_q  <= hs_in;
      vs_q  <= vs_in;
      de_q  <= de_in;
      pix_q <= {r_in, g_in, b_in};
      vs_q2 <= vs_q;
      de_q2 <= de_q;
    end
  end

  assign vs_fall = vs_q2 & ~vs_q;
  assign de_fall = de_q2 & ~de_q;

endmodule

// File: rtl/vga_capture.sv
// Decimating VGA frame capture: stores the top-left pixel of every
// DECIM x DECIM block into a frame buffer at row*OUT_W+col.
// Optional feature macro: VGA_CAPTURE_MEAS_EN (active-size measurement).
//
// state      | meaning
// WAIT_VS    | after reset, waiting for the first frame start
// ARMED      | frame-aligned, capture_en sampled at each frame start
// CAPTURE    | storing the current frame, ends at the next frame start
module vga_capture
  import vga_capture_pkg::*;
#(
  parameter int DECIM = DECIM_DEF,
  parameter int OUT_W = OUT_W_DEF,
  parameter int OUT_H = OUT_H_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  vga_capture_if.slave      vif,
  input  logic              capture_en,
  output logic              frame_done,
  output logic              short_frame,
  output logic [MEAS_W-1:0] meas_h_active,
  output logic [MEAS_W-1:0] meas_v_active
);

  localparam int CW = 16;
  localparam logic [CW-1:0]     ONE_C      = CW'(1);
  localparam logic [CW-1:0]     DECIM_LAST = CW'(DECIM - 1);
  localparam logic [CW-1:0]     OUT_W_C    = CW'(OUT_W);
  localparam logic [CW-1:0]     OUT_H_C    = CW'(OUT_H);
  localparam logic [ADDR_W-1:0] OUT_W_A    = ADDR_W'(OUT_W);

  cap_state_e        state, state_nxt;
  logic              hs_unused;
  logic              de_q;
  logic [PIX_W-1:0]  pix_q;
  logic              vs_fall;
  logic              de_fall;
  logic              frame_end;
  logic              wr_hit;
  logic [CW-1:0]     sub_col, col, sub_row, row;
  logic [ADDR_W-1:0] addr_calc;
  logic              wr_en_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [PIX_W-1:0]  wr_data_q;

  vga_sync_edge u_sync_edge (
    .clk     (clk),
    .reset_n (reset_n),
    .hs_in   (vif.vga_hs),
    .vs_in   (vif.vga_vs),
    .de_in   (vif.vga_de),
    .r_in    (vif.vga_r),
    .g_in    (vif.vga_g),
    .b_in    (vif.vga_b),
    .hs_q    (hs_unused),
    .de_q    (de_q),
    .pix_q   (pix_q),
    .vs_fall (vs_fall),
    .de_fall (de_fall)
  );

  // capture FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_WAIT_VS;
    else          state <= state_nxt;
  end

  // next state, frame-end pulse and write decision for the registered pixel
  always_comb begin
    state_nxt = state;
    frame_end = 1'b0;
    wr_hit    = 1'b0;
    unique case (state)
      ST_WAIT_VS: if (vs_fall) state_nxt = ST_ARMED;
      ST_ARMED:   if (vs_fall && capture_en) state_nxt = ST_CAPTURE;
      ST_CAPTURE: if (vs_fall) begin
        state_nxt = ST_ARMED;
        frame_end = 1'b1;
      end
      default:    state_nxt = ST_WAIT_VS;
    endcase
    wr_hit = (state == ST_CAPTURE) && de_q && (sub_col == '0) && (sub_row == '0) &&
             (col < OUT_W_C) && (row < OUT_H_C);
  end

  // block position counters; col/row stop at OUT_W/OUT_H so they never wrap
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sub_col <= '0;
      col     <= '0;
      sub_row <= '0;
      row     <= '0;
    end else if (vs_fall || (state != ST_CAPTURE)) begin
      sub_col <= '0;
      col     <= '0;
      sub_row <= '0;
      row     <= '0;
    end else if (de_fall) begin
      sub_col <= '0;
      col     <= '0;
      if (sub_row == DECIM_LAST) begin
        sub_row <= '0;
        if (row < OUT_H_C) row <= row + ONE_C;
      end else begin
        sub_row <= sub_row + ONE_C;
      end
    end else if (de_q) begin
      if (sub_col == DECIM_LAST) begin
        sub_col <= '0;
        if (col < OUT_W_C) col <= col + ONE_C;
      end else begin
        sub_col <= sub_col + ONE_C;
      end
    end
  end

  assign addr_calc = row[ADDR_W-1:0] * OUT_W_A + col[ADDR_W-1:0];

  // registered write port and end-of-frame status; a write decided in the
  // frame-start cycle still goes out because it uses pre-clear counters
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      frame_done  <= 1'b0;
      short_frame <= 1'b0;
    end else begin
      wr_en_q    <= wr_hit;
      frame_done <= frame_end;
      if (wr_hit) begin
        wr_addr_q <= addr_calc;
        wr_data_q <= pix_q;
      end
      if (frame_end) short_frame <= (row < OUT_H_C);
    end
  end

  assign vif.wr_en   = wr_en_q;
  assign vif.wr_addr = wr_addr_q;
  assign vif.wr_data = wr_data_q;

`ifdef VGA_CAPTURE_MEAS_EN
  localparam logic [MEAS_W-1:0] MEAS_ONE = MEAS_W'(1);

  logic [MEAS_W-1:0] h_cnt;
  logic [MEAS_W-1:0] h_line;
  logic [MEAS_W-1:0] v_cnt;

  // count de cycles per line and lines per frame, publish at frame start
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      h_cnt         <= '0;
      h_line        <= '0;
      v_cnt         <= '0;
      meas_h_active <= '0;
      meas_v_active <= '0;
    end else begin
      if (de_fall) begin
        h_line <= h_cnt;
        h_cnt  <= '0;
      end else if (de_q) begin
        h_cnt <= h_cnt + MEAS_ONE;
      end
      if (vs_fall)      v_cnt <= '0;
      else if (de_fall) v_cnt <= v_cnt + MEAS_ONE;
      if (vs_fall && (state != ST_WAIT_VS)) begin
        meas_h_active <= h_line;
        meas_v_active <= v_cnt;
      end
    end
  end
`else
  assign meas_h_active = '0;
  assign meas_v_active = '0;
`endif

endmodule
